i2c_master_arbiter: RTL and testbench

Round-robin scheduler that shares one `i2c_master` between `NUM_REQ` requesters and sequences its `start`/`stop` controls. It captures one requester's command (rw, 7-bit address, 8-bit write data), holds `start` for a fixed transfer window and `stop` for a fixed stop window, then reports completion to that requester. The block sits directly in front of `i2c_master`, whose `start`, `stop`, `rw`, `addr` and `w_data` inputs it drives.

---
 rtl/i2c_master_arbiter.sv | 134 +++++++++++++
 tb/tb_i2c_master_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// Round-robin front end for a shared i2c_master: captures one requester's
// command, holds m_start for the transfer window, m_stop for the stop window.
module i2c_master_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned XFER_CYCLES = 30,
  parameter int unsigned STOP_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  input  logic                   abort,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic                   m_start,
  output logic                   m_stop,
  output logic                   m_rw,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_w_data
);

  localparam int unsigned MAXC = (XFER_CYCLES > STOP_CYCLES) ? XFER_CYCLES : STOP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned IW   = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, XFER, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        last_q, last_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 m_rw_q, m_rw_d;
  logic [6:0]           m_addr_q, m_addr_d;
  logic [7:0]           m_w_data_q, m_w_data_d;

  logic                 found;
  logic [IW-1:0]        win;
  int unsigned          idx;

  // Search starts just after the last winner and wraps around.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_q) + off) % NUM_REQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = '0;
    done_d     = '0;
    m_rw_d     = m_rw_q;
    m_addr_d   = m_addr_q;
    m_w_data_d = m_w_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          last_d     = win;
          m_rw_d     = req_rw[win];
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == win) begin
              m_addr_d   = req_addr[7*i +: 7];
              m_w_data_d = req_wdata[8*i +: 8];
            end
          end
          cnt_d   = CW'(XFER_CYCLES - 1);
          state_d = XFER;
        end
      end
      XFER: begin
        if (cnt_q == '0 || abort) begin
          cnt_d   = CW'(STOP_CYCLES - 1);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          done_d[last_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      m_rw_q     <= 1'b0;
      m_addr_q   <= '0;
      m_w_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      m_rw_q     <= m_rw_d;
      m_addr_q   <= m_addr_d;
      m_w_data_q <= m_w_data_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign m_start  = (state_q == XFER);
  assign m_stop   = (state_q == STOP);
  assign m_rw     = m_rw_q;
  assign m_addr   = m_addr_q;
  assign m_w_data = m_w_data_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: directed test-plan steps plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_i2c_master_arbiter;
  localparam int N  = 4;
  localparam int XC = 30;
  localparam int SC = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     req_rw = '0;
  logic [7*N-1:0]   req_addr = '0;
  logic [8*N-1:0]   req_wdata = '0;
  logic             abort = 1'b0;
  logic [N-1:0]     gnt, done;
  logic             busy, m_start, m_stop, m_rw;
  logic [6:0]       m_addr;
  logic [7:0]       m_w_data;

  i2c_master_arbiter #(.NUM_REQ(N), .XFER_CYCLES(XC), .STOP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .abort(abort), .gnt(gnt), .done(done), .busy(busy),
    .m_start(m_start), .m_stop(m_stop), .m_rw(m_rw), .m_addr(m_addr), .m_w_data(m_w_data)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: a transfer owns the bus for a number of start cycles
  // followed by a number of stop cycles; expected outputs are derived from those.
  bit           md_active = 1'b0;
  int           md_xleft = 0;
  int           md_sleft = 0;
  int           md_last = N - 1;
  logic [N-1:0] e_gnt = '0, e_done = '0;
  logic         e_rw = 1'b0;
  logic [6:0]   e_addr = '0;
  logic [7:0]   e_wd = '0;
  int           cyc = 0;
  int           st_cnt = 0;
  int           sp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    bit found;
    int w;
    e_gnt  = '0;
    e_done = '0;
    if (!reset) begin
      md_active = 1'b0;
      md_last   = N - 1;
      e_rw      = 1'b0;
      e_addr    = '0;
      e_wd      = '0;
    end else if (!md_active) begin
      found = 1'b0;
      w = 0;
      for (int k = 1; k <= N; k++) begin
        int i = (md_last + k) % N;
        if (!found && req[i]) begin
          found = 1'b1;
          w = i;
        end
      end
      if (found) begin
        e_gnt[w]  = 1'b1;
        md_last   = w;
        e_rw      = req_rw[w];
        e_addr    = req_addr[7*w +: 7];
        e_wd      = req_wdata[8*w +: 8];
        md_active = 1'b1;
        md_xleft  = XC;
        md_sleft  = SC;
      end
    end else if (md_xleft > 0) begin
      md_xleft--;
      if (abort) md_xleft = 0;
    end else begin
      md_sleft--;
      if (md_sleft == 0) begin
        md_active       = 1'b0;
        e_done[md_last] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (m_start === 1'b1) st_cnt++;
    if (m_stop === 1'b1) sp_cnt++;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(md_active));
    chk("m_start", 32'(m_start), 32'(md_active && md_xleft > 0));
    chk("m_stop", 32'(m_stop), 32'(md_active && md_xleft == 0));
    chk("m_rw", 32'(m_rw), 32'(e_rw));
    chk("m_addr", 32'(m_addr), 32'(e_addr));
    chk("m_w_data", 32'(m_w_data), 32'(e_wd));
  endtask

  task automatic wait_gnt(input string tag, input int max);
    for (int t = 0; t < max; t++) begin
      tick();
      if (gnt != '0) break;
    end
    chk(tag, 32'(gnt != '0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    for (int t = 0; t < max; t++) begin
      tick();
      n++;
      if (done != '0) break;
    end
    chk(tag, 32'(done != '0), 32'd1);
  endtask

  initial begin
    int n;
    int order[$];
    int gcyc[$];
    int exp_o[6] = '{0, 1, 3, 0, 1, 3};
    int gcount;

    // Reset held with all requests pending.
    reset = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    chk("rst_gnt_quiet", 32'(gnt), 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    wait_done("rst_done_timeout", 100, n);

    // Single write from requester 2.
    req_rw    = 4'b0000;
    req_addr[14 +: 7]  = 7'h55;
    req_wdata[16 +: 8] = 8'haa;
    req       = 4'b0100;
    st_cnt = 0;
    sp_cnt = 0;
    tick();
    chk("wr_gnt", 32'(gnt), 32'b0100);
    req = '0;
    wait_done("wr_done_timeout", 100, n);
    chk("wr_done_cycle", 32'(n + 1), 32'd36);
    chk("wr_start_cycles", 32'(st_cnt), 32'd30);
    chk("wr_stop_cycles", 32'(sp_cnt), 32'd5);
    chk("wr_done_idx", 32'(done), 32'b0100);

    // Round robin with 0,1,3 requesting continuously.
    reset = 1'b0;
    req   = 4'b1011;
    req_addr  = {7'h11, 7'h22, 7'h33, 7'h44};
    req_wdata = {8'h12, 8'h34, 8'h56, 8'h78};
    tick();
    reset = 1'b1;
    for (int t = 0; t < 400 && order.size() < 6; t++) begin
      tick();
      if (gnt != '0) begin
        order.push_back(onehot_idx(gnt));
        gcyc.push_back(cyc);
      end
    end
    chk("rr_grant_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size() && i < 6; i++) chk("rr_order", 32'(order[i]), 32'(exp_o[i]));
    for (int i = 1; i < gcyc.size(); i++) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd36);
    req = '0;
    wait_done("rr_done_timeout", 100, n);

    // Read from requester 1 held through done, then re-granted.
    req_rw = 4'b0010;
    req_addr[7 +: 7]  = 7'h55;
    req_wdata[8 +: 8] = 8'h01;
    req = 4'b0010;
    wait_gnt("rd_gnt_timeout", 10);
    chk("rd_gnt", 32'(gnt), 32'b0010);
    chk("rd_m_rw", 32'(m_rw), 32'd1);
    wait_done("rd_done_timeout", 100, n);
    tick();
    chk("rd_regrant", 32'(gnt), 32'b0010);
    req = '0;
    wait_done("rd2_done_timeout", 100, n);

    // Abort sampled in XFER cycle 10.
    req_rw = '0;
    req = 4'b0001;
    wait_gnt("ab_gnt_timeout", 10);
    req = '0;
    for (int t = 0; t < 9; t++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_start_low", 32'(m_start), 32'd0);
    chk("ab_stop_high", 32'(m_stop), 32'd1);
    sp_cnt = 1;
    wait_done("ab_done_timeout", 20, n);
    chk("ab_done_cycle", 32'(11 + n), 32'd16);
    chk("ab_stop_cycles", 32'(sp_cnt), 32'd5);

    // Reset during STOP drops the transfer.
    req = 4'b0100;
    wait_gnt("mr_gnt_timeout", 10);
    req = '0;
    for (int t = 0; t < 32; t++) tick();
    chk("mr_in_stop", 32'(m_stop), 32'd1);
    reset = 1'b0;
    tick();
    chk("mr_busy_clear", 32'(busy), 32'd0);
    chk("mr_addr_clear", 32'(m_addr), 32'd0);
    reset = 1'b1;
    gcount = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done != '0) gcount++;
    end
    chk("mr_no_done", 32'(gcount), 32'd0);

    // Withdrawn request from 3 while 0 is served.
    req = 4'b0001;
    tick();
    chk("wd_gnt0", 32'(gnt), 32'b0001);
    req = 4'b1000;
    for (int t = 0; t < 10; t++) tick();
    req = '0;
    gcount = 0;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (gnt != '0) gcount++;
    end
    chk("wd_no_more_gnt", 32'(gcount), 32'd0);

    // Random traffic.
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_rw    = N'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
      end
      abort = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1;
    abort = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
